reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Consumes the synchronised system reset `rst` and produces staged, per-subsystem reset releases with a programmable delay between stages.
- Typical ordering: SPI/host interface, motion engine, step generators, motor-driver enable.
- On a fault it re-asserts stage resets in reverse order, holds in a latched fault state, and restarts the sequence on an explicit clear.
- Sits directly downstream of the system reset synchroniser and upstream of every subsystem reset/enable.

Parameters:
- NUM_STAGES, 4, number of staged reset outputs (legal range 1..8).
- STAGE_DELAY, 1000, clock cycles between successive stage releases (>=1).
- SHUT_DELAY, 16, clock cycles between successive stage re-assertions during shutdown (>=1).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset; one clock; reset is synchronous and active-high.
- fault  input  1  level fault request (e.g. e-stop, limit, driver fault); synchronous to clk.
- fault_clr  input  1  single-cycle fault clear request.
- stage_rst  output  NUM_STAGES  active-high reset per stage; bit 0 released first.
- ready  output  1  high when all stages are released (RUN state).
- faulted  output  1  high in FAULT state.
- busy  output  1  high while sequencing up or down (UP or DOWN state).

Behaviour:
- States:
  - UP: releasing stages.
  - RUN: all stages released.
  - DOWN: re-asserting stages.
  - FAULT: all stages held.
- All outputs are registered.
- rst=1, sampled at any edge, in any state:
  - stage_rst = all ones, ready=0, faulted=0, busy=1.
  - State=UP, timer=0, stage index idx=0.
  - Reset mid-sequence or mid-shutdown forces all stages back into reset on that same edge.
- Timing reference: edge 1 is the first edge sampling rst=0.
- UP:
  - The timer increments every edge.
  - When the timer reaches STAGE_DELAY-1, the next edge clears stage_rst[idx], increments idx and zeroes the timer.
  - Stage k is released at edge (k+1)*STAGE_DELAY.
  - The edge that releases stage NUM_STAGES-1 also sets ready=1, busy=0 and state=RUN.
- RUN: outputs are stable; the timer is idle at 0.
- Fault in UP or RUN, with fault=1 sampled at edge N:
  - At edge N: ready=0, the highest released stage is re-asserted, the timer is zeroed and busy=1.
  - If that stage was stage 0, or no stage had been released yet, state=FAULT and faulted=1 at edge N.
  - Otherwise state=DOWN.
- DOWN:
  - Every SHUT_DELAY edges, the next-lower stage is re-asserted.
  - The edge that re-asserts stage 0 sets state=FAULT, faulted=1 and busy=0.
  - fault and fault_clr are ignored in DOWN.
- FAULT:
  - stage_rst stays all ones.
  - fault_clr=1 with fault=0 at edge M sets faulted=0, busy=1, state=UP, idx=0, timer=0.
  - Stage 0 is then released at edge M+STAGE_DELAY.
  - fault_clr with fault=1 is ignored.
- fault_clr outside FAULT is ignored.
- fault and fault_clr sampled on the same edge in UP/RUN: fault wins.
- Timer width: $clog2(max(STAGE_DELAY,SHUT_DELAY)+1) bits. The timer never wraps; it compares equal and reloads to 0.
- stage_rst bits above the current shutdown index never release again until the sequence restarts.
- Stage releases are strictly monotone:
  - No two stages change on the same edge, except a fault at an edge where a release was due; the fault takes priority and no release occurs.

Decomposition:
- Package robot_rst_pkg contains:
  - A 2-bit state encoding: UP=0, RUN=1, DOWN=2, FAULT=3.
  - Parameter-range check constants (MAX_STAGES=8).
- Sub-module seq_timer:
  - Loadable up-counter with clear, enable and terminal-count compare against a runtime-selected limit (STAGE_DELAY-1 or SHUT_DELAY-1).
  - The top level holds the FSM, idx and output registers.

Test Plan (NUM_STAGES=3, STAGE_DELAY=4, SHUT_DELAY=2):
- Power-up: rst=1 for 5 cycles, then 0 -> stage_rst: 111 through edge 3, 110 at edge 4, 100 at edge 8, 000 at edge 12. ready=1 and busy=0 at edge 12.
- RUN fault: fault=1 at edge 20 -> ready=0 and stage_rst=100 at 20, 110 at 22, 111 at 24. faulted=1 and busy=0 at 24.
- Early fault: fault=1 at edge 6 (only stage 0 released) -> stage_rst=111 and faulted=1 at edge 6; no DOWN state entered.
- Clear handling:
  - fault_clr with fault=1 in FAULT -> no change.
  - fault=0, fault_clr at edge M -> faulted=0 at M; stage_rst=110 at M+4, 000 at M+12.
- Reset mid-operation: rst=1 at edge 9 during UP, and again during DOWN -> stage_rst=111, ready=0, faulted=0 on that edge. Sequence restarts with a release at +4 after rst drops.
- Priority: fault and fault_clr both high at edge 4 -> fault wins; stage_rst stays 111 and faulted=1.

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the staged reset sequencer: state encoding,
// stage-count limits and small elaboration-time helpers.
package robot_rst_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_UP    = 2'd0,
    ST_RUN   = 2'd1,
    ST_DOWN  = 2'd2,
    ST_FAULT = 2'd3
  } seq_state_e;

  // Legal range of NUM_STAGES
  localparam int MIN_STAGES = 1;
  localparam int MAX_STAGES = 8;

  // Stage index counts released stages, so it must hold 0..MAX_STAGES
  localparam int IDX_W = $clog2(MAX_STAGES + 1);

  // Larger of two integers, used to size the shared delay timer
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_seq_timer.sv
// Delay timer for the reset sequencer. Counts up while enabled and reloads
// to zero when it reaches the runtime-selected limit, so it never wraps.
// The terminal-count flag tells the FSM that the current delay has expired.
module seq_timer
  #(parameter int W = 4)
  (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         tc
  );

  logic [W-1:0] count_r;

  // Terminal count: the edge on which this is seen ends the delay
  assign tc = (count_r == limit);

  // Count up while enabled, reload to zero at the limit or on clear
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (en) begin
      if (tc) begin
        count_r <= {W{1'b0}};
      end else begin
        count_r <= count_r + W'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset sequencer. Releases NUM_STAGES subsystem resets one at a
// time (bit 0 first) with STAGE_DELAY cycles between releases. A fault
// re-asserts released stages highest-first, SHUT_DELAY cycles apart, then
// latches in FAULT until fault_clr arrives with fault low.
// NUM_STAGES must lie within MIN_STAGES..MAX_STAGES; both delays must be >= 1.
module reset_sequencer
  import robot_rst_pkg::*;
  #(
    parameter int NUM_STAGES  = 4,
    parameter int STAGE_DELAY = 1000,
    parameter int SHUT_DELAY  = 16
  )
  (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fault,
    input  logic                  fault_clr,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  ready,
    output logic                  faulted,
    output logic                  busy
  );

  localparam int TMR_W = $clog2(max_int(STAGE_DELAY, SHUT_DELAY) + 1);

  localparam logic [TMR_W-1:0]      STAGE_LIM = TMR_W'(STAGE_DELAY - 1);
  localparam logic [TMR_W-1:0]      SHUT_LIM  = TMR_W'(SHUT_DELAY - 1);
  localparam logic [IDX_W-1:0]      ONE_IDX   = IDX_W'(1);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] STAGE_ONE = NUM_STAGES'(1);
  localparam logic [NUM_STAGES-1:0] ALL_HELD  = {NUM_STAGES{1'b1}};

  seq_state_e              state_r;
  logic [IDX_W-1:0]        idx_r;        // number of stages currently released
  logic [NUM_STAGES-1:0]   stage_rst_r;
  logic                    ready_r;
  logic                    faulted_r;
  logic                    busy_r;

  logic                    tmr_clr_s;
  logic                    tmr_en_s;
  logic [TMR_W-1:0]        tmr_lim_s;
  logic                    tmr_tc_s;
  logic [NUM_STAGES-1:0]   release_mask_s;  // next stage to release
  logic [NUM_STAGES-1:0]   top_mask_s;      // highest released stage

  assign release_mask_s = STAGE_ONE << idx_r;
  assign top_mask_s     = STAGE_ONE << (idx_r - ONE_IDX);

  // Timer control: run in UP/DOWN, held at zero in RUN/FAULT and on fault entry
  always_comb begin
    tmr_clr_s = 1'b0;
    tmr_en_s  = 1'b0;
    tmr_lim_s = STAGE_LIM;
    case (state_r)
      ST_UP: begin
        if (fault) begin
          tmr_clr_s = 1'b1;
        end else begin
          tmr_en_s = 1'b1;
        end
      end
      ST_DOWN: begin
        tmr_en_s  = 1'b1;
        tmr_lim_s = SHUT_LIM;
      end
      ST_RUN: begin
        tmr_clr_s = 1'b1;
      end
      ST_FAULT: begin
        tmr_clr_s = 1'b1;
      end
      default: begin
        tmr_clr_s = 1'b1;
      end
    endcase
  end

  seq_timer #(.W(TMR_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr_s),
    .en    (tmr_en_s),
    .limit (tmr_lim_s),
    .tc    (tmr_tc_s)
  );

  // Sequencer FSM with registered stage resets and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_UP;
      idx_r       <= {IDX_W{1'b0}};
      stage_rst_r <= ALL_HELD;
      ready_r     <= 1'b0;
      faulted_r   <= 1'b0;
      busy_r      <= 1'b1;
    end else begin
      case (state_r)
        ST_UP, ST_RUN: begin
          if (fault) begin
            // Fault beats any release due on this edge
            ready_r <= 1'b0;
            if (idx_r <= ONE_IDX) begin
              // Nothing or only stage 0 released: straight to FAULT
              stage_rst_r <= ALL_HELD;
              idx_r       <= {IDX_W{1'b0}};
              state_r     <= ST_FAULT;
              faulted_r   <= 1'b1;
              busy_r      <= 1'b0;
            end else begin
              stage_rst_r <= stage_rst_r | top_mask_s;
              idx_r       <= idx_r - ONE_IDX;
              state_r     <= ST_DOWN;
              busy_r      <= 1'b1;
            end
          end else if ((state_r == ST_UP) && tmr_tc_s) begin
            stage_rst_r <= stage_rst_r & ~release_mask_s;
            idx_r       <= idx_r + ONE_IDX;
            if (idx_r == LAST_IDX) begin
              state_r <= ST_RUN;
              ready_r <= 1'b1;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_UP;
            end
          end else begin
            state_r <= state_r;
          end
        end
        ST_DOWN: begin
          // fault and fault_clr are deliberately ignored while shutting down
          if (tmr_tc_s) begin
            stage_rst_r <= stage_rst_r | top_mask_s;
            idx_r       <= idx_r - ONE_IDX;
            if (idx_r == ONE_IDX) begin
              state_r   <= ST_FAULT;
              faulted_r <= 1'b1;
              busy_r    <= 1'b0;
            end else begin
              state_r <= ST_DOWN;
            end
          end else begin
            state_r <= ST_DOWN;
          end
        end
        ST_FAULT: begin
          stage_rst_r <= ALL_HELD;
          if (fault_clr && !fault) begin
            state_r   <= ST_UP;
            idx_r     <= {IDX_W{1'b0}};
            faulted_r <= 1'b0;
            busy_r    <= 1'b1;
          end else begin
            state_r <= ST_FAULT;
          end
        end
        default: begin
          // Unreachable encoding: fail safe with everything held in reset
          state_r     <= ST_FAULT;
          idx_r       <= {IDX_W{1'b0}};
          stage_rst_r <= ALL_HELD;
          ready_r     <= 1'b0;
          faulted_r   <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign stage_rst = stage_rst_r;
  assign ready     = ready_r;
  assign faulted   = faulted_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with NUM_STAGES=3, STAGE_DELAY=4,
// SHUT_DELAY=2. Edge numbers in comments count from the first edge that
// samples rst=0 after the most recent reset.
module tb_reset_sequencer;

  logic       clk;
  logic       rst;
  logic       fault;
  logic       fault_clr;
  logic [2:0] stage_rst;
  logic       ready;
  logic       faulted;
  logic       busy;

  int checks;
  int failures;

  reset_sequencer #(
    .NUM_STAGES  (3),
    .STAGE_DELAY (4),
    .SHUT_DELAY  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fault     (fault),
    .fault_clr (fault_clr),
    .stage_rst (stage_rst),
    .ready     (ready),
    .faulted   (faulted),
    .busy      (busy)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge and settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] e_stage,
                         input logic e_ready, input logic e_faulted, input logic e_busy);
    chk({tag, ".stage_rst"}, {5'd0, stage_rst}, {5'd0, e_stage});
    chk({tag, ".ready"},     {7'd0, ready},     {7'd0, e_ready});
    chk({tag, ".faulted"},   {7'd0, faulted},   {7'd0, e_faulted});
    chk({tag, ".busy"},      {7'd0, busy},      {7'd0, e_busy});
  endtask

  // Run n edges of a clean power-up sequence, checking every edge
  task automatic up_seq(input string tag, input int n);
    logic [2:0] e_stage;
    for (int e = 1; e <= n; e++) begin
      tick();
      if (e < 4)       e_stage = 3'b111;
      else if (e < 8)  e_stage = 3'b110;
      else if (e < 12) e_stage = 3'b100;
      else             e_stage = 3'b000;
      chk_all($sformatf("%s.e%0d", tag, e), e_stage, (e >= 12), 1'b0, (e < 12));
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    fault     = 1'b0;
    fault_clr = 1'b0;

    // Power-up reset
    repeat (5) tick();
    chk_all("reset", 3'b111, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    up_seq("pwr", 12);

    // RUN holds steady
    repeat (7) tick();                             // edge 19
    chk_all("run_e19", 3'b000, 1'b1, 1'b0, 1'b0);

    // Fault in RUN, sampled at edge 20
    fault = 1'b1;
    tick();                                        // edge 20
    chk_all("runflt_e20", 3'b100, 1'b0, 1'b0, 1'b1);
    fault = 1'b0;                                  // ignored in DOWN
    tick();                                        // edge 21
    chk_all("runflt_e21", 3'b100, 1'b0, 1'b0, 1'b1);
    tick();                                        // edge 22
    chk_all("runflt_e22", 3'b110, 1'b0, 1'b0, 1'b1);
    fault_clr = 1'b1;                              // ignored in DOWN
    tick();                                        // edge 23
    chk_all("runflt_e23", 3'b110, 1'b0, 1'b0, 1'b1);
    fault_clr = 1'b0;
    tick();                                        // edge 24
    chk_all("runflt_e24", 3'b111, 1'b0, 1'b1, 1'b0);

    // Clear while fault still high is ignored
    fault     = 1'b1;
    fault_clr = 1'b1;
    tick();                                        // edge 25
    chk_all("clr_blocked", 3'b111, 1'b0, 1'b1, 1'b0);
    fault     = 1'b0;
    fault_clr = 1'b0;
    tick();                                        // edge 26
    chk_all("fault_latched", 3'b111, 1'b0, 1'b1, 1'b0);

    // Valid clear at edge M, then restart releases at M+4, M+8, M+12
    fault_clr = 1'b1;
    tick();                                        // edge M
    chk_all("clr_M", 3'b111, 1'b0, 1'b0, 1'b1);
    fault_clr = 1'b0;
    up_seq("restart", 12);

    // Reset from RUN
    rst = 1'b1;
    tick();
    chk_all("rst_run", 3'b111, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;

    // Early fault at edge 6: only stage 0 released, straight to FAULT
    up_seq("early", 5);
    fault = 1'b1;
    tick();                                        // edge 6
    chk("early_e6.stage_rst", {5'd0, stage_rst}, 8'h07);
    chk("early_e6.ready",     {7'd0, ready},     8'h00);
    chk("early_e6.faulted",   {7'd0, faulted},   8'h01);
    tick();                                        // edge 7
    chk_all("early_e7", 3'b111, 1'b0, 1'b1, 1'b0);
    fault = 1'b0;

    // Reset from FAULT
    rst = 1'b1;
    tick();
    chk_all("rst_fault", 3'b111, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;

    // Reset mid-UP at edge 9
    up_seq("mid_up", 8);
    rst = 1'b1;
    tick();                                        // edge 9
    chk_all("rst_up_e9", 3'b111, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    up_seq("after_up_rst", 12);

    // Reset mid-DOWN
    fault = 1'b1;
    tick();
    chk_all("down_entry", 3'b100, 1'b0, 1'b0, 1'b1);
    fault = 1'b0;
    rst   = 1'b1;
    tick();
    chk_all("rst_down", 3'b111, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;

    // fault and fault_clr together at edge 4 where a release is due
    up_seq("prio", 3);
    fault     = 1'b1;
    fault_clr = 1'b1;
    tick();                                        // edge 4
    chk_all("prio_e4", 3'b111, 1'b0, 1'b1, 1'b0);
    fault     = 1'b0;
    fault_clr = 1'b0;
    tick();                                        // edge 5
    chk_all("prio_e5", 3'b111, 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
